// File: rtl/mult_add_pkg.sv
// -----------------------------------------------------------------------------
// mult_add_pkg
// Shared types for the sequential shift-add multiply-accumulate unit.
// Contents:
//   state_t - control state of multiply_add (IDLE, MUL, ADD)
// -----------------------------------------------------------------------------
package mult_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2
    } state_t;

endpackage : mult_add_pkg

// File: rtl/multiply_add.sv
// -----------------------------------------------------------------------------
// multiply_add
// Sequential unsigned multiply-accumulate: p = a*b + c.
// One partial product is folded in per clock using a right-shift scheme,
// followed by a single cycle that adds the addend. Latency is constant
// (WIDTH+1 cycles of busy); the result is held until the next start.
//
// Parameters:
//   WIDTH  operand width in bits (2..32)
// Ports:
//   clk    in   1        clock, rising edge
//   rst_n  in   1        asynchronous active-low reset
//   start  in   1        one-cycle request; samples a, b, c (also aborts/restarts)
//   busy   out  1        calculation in progress
//   valid  out  1        p/ovf hold the result of the last completed operation
//   ovf    out  1        result does not fit in WIDTH bits
//   a      in   WIDTH    multiplicand
//   b      in   WIDTH    multiplier
//   c      in   WIDTH    addend
//   p      out  2*WIDTH  result a*b+c
// -----------------------------------------------------------------------------
module multiply_add
    import mult_add_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               valid,
    output logic               ovf,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   c,
    output logic [2*WIDTH-1:0] p
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);

    state_t               state_q, state_d;
    logic [WIDTH:0]       acc_q, acc_d;      // upper product half plus carry bit
    logic [WIDTH-1:0]     mplr_q, mplr_d;    // multiplier, refilled with product LSBs
    logic [WIDTH-1:0]     a_l_q, a_l_d;
    logic [WIDTH-1:0]     c_l_q, c_l_d;
    logic [IW-1:0]        i_q, i_d;
    logic                 busy_q, busy_d;
    logic                 valid_q, valid_d;
    logic                 ovf_q, ovf_d;
    logic [2*WIDTH-1:0]   p_q, p_d;

    // Datapath helpers
    logic [WIDTH:0]       step_sum;
    logic [2*WIDTH-1:0]   product;
    logic [2*WIDTH-1:0]   result;

    // acc bit WIDTH is always zero at the start of an iteration (it was just
    // shifted out), so this WIDTH+1 add cannot lose a carry.
    assign step_sum = acc_q + (mplr_q[0] ? {1'b0, a_l_q} : {(WIDTH+1){1'b0}});
    assign product  = {acc_q[WIDTH-1:0], mplr_q};
    // Max a*b+c < 2^(2*WIDTH), so this add never wraps.
    assign result   = product + {{WIDTH{1'b0}}, c_l_q};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mplr_d  = mplr_q;
        a_l_d   = a_l_q;
        c_l_d   = c_l_q;
        i_d     = i_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        p_d     = p_q;

        if (start) begin
            // A start in any state (including MUL or the ADD cycle) restarts
            // the operation; the interrupted result is never flagged valid.
            state_d = MUL;
            acc_d   = '0;
            mplr_d  = b;
            a_l_d   = a;
            c_l_d   = c;
            i_d     = '0;
            busy_d  = 1'b1;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                MUL: begin
                    // {acc, mplr} >>= 1 after the conditional add
                    acc_d  = {1'b0, step_sum[WIDTH:1]};
                    mplr_d = {step_sum[0], mplr_q[WIDTH-1:1]};
                    if (i_q == I_LAST) begin
                        state_d = ADD;
                    end else begin
                        i_d = i_q + 1'b1;
                    end
                end
                ADD: begin
                    p_d     = result;
                    ovf_d   = |result[2*WIDTH-1:WIDTH];
                    busy_d  = 1'b0;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            mplr_q  <= '0;
            a_l_q   <= '0;
            c_l_q   <= '0;
            i_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mplr_q  <= mplr_d;
            a_l_q   <= a_l_d;
            c_l_q   <= c_l_d;
            i_q     <= i_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            p_q     <= p_d;
        end
    end

    assign busy  = busy_q;
    assign valid = valid_q;
    assign ovf   = ovf_q;
    assign p     = p_q;

endmodule : multiply_add

// File: tb/tb_multiply_add.sv
// -----------------------------------------------------------------------------
// tb_multiply_add
// Self-checking bench for multiply_add: a WIDTH=4 instance driven from a
// vector table plus hand-written abort/restart/reset sequences, and a WIDTH=8
// instance driven with random back-to-back operations checked against a*b+c.
// -----------------------------------------------------------------------------
module tb_multiply_add;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // WIDTH=4 instance
    logic       s4;
    logic [3:0] a4, b4, c4;
    logic       busy4, valid4, ovf4;
    logic [7:0] p4;

    // WIDTH=8 instance
    logic        s8;
    logic [7:0]  a8, b8, c8;
    logic        busy8, valid8, ovf8;
    logic [15:0] p8;

    multiply_add #(.WIDTH(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s4),
        .busy  (busy4),
        .valid (valid4),
        .ovf   (ovf4),
        .a     (a4),
        .b     (b4),
        .c     (c4),
        .p     (p4)
    );

    multiply_add #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (s8),
        .busy  (busy8),
        .valid (valid8),
        .ovf   (ovf8),
        .a     (a8),
        .b     (b8),
        .c     (c8),
        .p     (p8)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Raise start for exactly one rising edge; returns at the negedge after it.
    task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        @(negedge clk);
        a4 = a; b4 = b; c4 = c; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom);
    endtask

    // Called at the negedge right after the start edge. lat counts edges
    // from the start edge to the one that raised valid; bcnt counts cycles
    // busy was seen high before valid. Bounded at 20 cycles.
    task automatic wait_valid4(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!valid4 && lat < 20) begin
            if (busy4) bcnt++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_valid8(output int lat);
        lat = 0;
        while (!valid8 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [7:0] p;
        logic       ovf;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int lat, bcnt;
        longint unsigned exp_p;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  c: 4'd2,  p: 8'd17,  ovf: 1'b1};
        vecs[1] = '{a: 4'd2,  b: 4'd6,  c: 4'd1,  p: 8'd13,  ovf: 1'b0};
        vecs[2] = '{a: 4'd15, b: 4'd15, c: 4'd15, p: 8'd240, ovf: 1'b1};
        vecs[3] = '{a: 4'd0,  b: 4'd9,  c: 4'd7,  p: 8'd7,   ovf: 1'b0};
        vecs[4] = '{a: 4'd5,  b: 4'd0,  c: 4'd15, p: 8'd15,  ovf: 1'b0};
        vecs[5] = '{a: 4'd15, b: 4'd1,  c: 4'd0,  p: 8'd15,  ovf: 1'b0};
        vecs[6] = '{a: 4'd4,  b: 4'd4,  c: 4'd0,  p: 8'd16,  ovf: 1'b1};
        vecs[7] = '{a: 4'd1,  b: 4'd1,  c: 4'd0,  p: 8'd1,   ovf: 1'b0};
        vecs[8] = '{a: 4'd9,  b: 4'd13, c: 4'd6,  p: 8'd123, ovf: 1'b1};

        rst_n = 1'b0;
        s4 = 1'b0; a4 = '0; b4 = '0; c4 = '0;
        s8 = 1'b0; a8 = '0; b8 = '0; c8 = '0;

        repeat (2) @(negedge clk);
        check("reset_busy",  busy4,  0);
        check("reset_valid", valid4, 0);
        check("reset_ovf",   ovf4,   0);
        check("reset_p",     p4,     0);
        rst_n = 1'b1;

        // ---- table-driven single operations (WIDTH=4) ----
        for (int v = 0; v < 9; v++) begin
            start4(vecs[v].a, vecs[v].b, vecs[v].c);
            check("start_busy", busy4, 1);
            wait_valid4(lat, bcnt);
            $display("op4 a=%0d b=%0d c=%0d -> p=%0d ovf=%0d lat=%0d",
                     vecs[v].a, vecs[v].b, vecs[v].c, p4, ovf4, lat);
            check("latency", lat, 5);
            check("busy_cycles", bcnt, 5);
            check("busy_low_at_valid", busy4, 0);
            check("p", p4, vecs[v].p);
            check("ovf", ovf4, vecs[v].ovf);
        end

        // valid is a level: result held while idle
        repeat (3) @(negedge clk);
        check("hold_valid", valid4, 1);
        check("hold_p", p4, vecs[8].p);
        check("hold_ovf", ovf4, vecs[8].ovf);

        // ---- abort: second start two cycles after the first ----
        start4(4'd1, 4'd1, 4'd0);
        start4(4'd4, 4'd4, 4'd3);
        wait_valid4(lat, bcnt);
        $display("abort a=4 b=4 c=3 -> p=%0d ovf=%0d lat=%0d", p4, ovf4, lat);
        check("abort_latency", lat, 5);
        check("abort_p", p4, 19);
        check("abort_ovf", ovf4, 1);

        // ---- restart on the ADD cycle: restart wins, valid stays 0 ----
        start4(4'd3, 4'd5, 4'd2);
        repeat (4) @(negedge clk);
        a4 = 4'd2; b4 = 4'd6; c4 = 4'd1; s4 = 1'b1;
        @(negedge clk);
        s4 = 1'b0;
        check("add_restart_valid", valid4, 0);
        check("add_restart_busy", busy4, 1);
        wait_valid4(lat, bcnt);
        $display("add-cycle restart a=2 b=6 c=1 -> p=%0d ovf=%0d lat=%0d", p4, ovf4, lat);
        check("add_restart_latency", lat, 5);
        check("add_restart_p", p4, 13);
        check("add_restart_ovf", ovf4, 0);

        // ---- asynchronous reset in the middle of MUL ----
        start4(4'd9, 4'd9, 4'd9);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        $display("async reset mid-MUL -> busy=%0d valid=%0d ovf=%0d p=%0d",
                 busy4, valid4, ovf4, p4);
        check("areset_busy",  busy4,  0);
        check("areset_valid", valid4, 0);
        check("areset_ovf",   ovf4,   0);
        check("areset_p",     p4,     0);
        @(negedge clk);
        rst_n = 1'b1;
        start4(4'd7, 4'd2, 4'd0);
        wait_valid4(lat, bcnt);
        $display("post-reset a=7 b=2 c=0 -> p=%0d ovf=%0d lat=%0d", p4, ovf4, lat);
        check("post_reset_latency", lat, 5);
        check("post_reset_p", p4, 14);
        check("post_reset_ovf", ovf4, 0);

        // ---- WIDTH=8 random sweep, back-to-back starts on the valid cycle ----
        @(negedge clk);
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb, rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 8'($urandom);
            if (i % 97 == 0) begin
                ra = 8'hFF; rb = 8'hFF; rc = 8'hFF;
            end
            a8 = ra; b8 = rb; c8 = rc; s8 = 1'b1;
            @(negedge clk);
            s8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
            check("sweep_valid_drop", valid8, 0);
            check("sweep_busy", busy8, 1);
            wait_valid8(lat);
            exp_p = longint'(ra) * longint'(rb) + longint'(rc);
            $display("op8 #%0d a=%0d b=%0d c=%0d -> p=%0d (model %0d) ovf=%0d lat=%0d",
                     i, ra, rb, rc, p8, exp_p, ovf8, lat);
            check("sweep_latency", lat, 9);
            check("sweep_p", p8, exp_p);
            check("sweep_ovf", ovf8, ((exp_p >> 8) != 0) ? 1 : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_multiply_add
